// File: rtl/dot_product_feeder.sv
// Vector source for the dot-product engine: buffers A/B, drives start/data_in/stop
// on the engine cadence and keeps a golden wrapped running sum of A[i]*B[i].
module dot_product_feeder #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned SUM_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              start,
  output logic              stop,
  output logic [WIDTH-1:0]  data_out,
  output logic [SUM_W-1:0]  expected
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, START, CLEAR, SEND_A, SEND_B, ACC, FIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SUM_W-1:0]   expected_d;
  logic               busy_d, done_d, err_d, start_d, stop_d;
  logic [WIDTH-1:0]   data_d;
  logic [PROD_W-1:0]  prod;
  logic               len_ok;
  logic               last;

  logic [WIDTH-1:0]   mem_a [DEPTH];
  logic [WIDTH-1:0]   mem_b [DEPTH];

  assign len_ok = (len != '0) && (len <= LEN_W'(DEPTH));
  assign last   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  assign prod   = PROD_W'(mem_a[idx_q]) * PROD_W'(mem_b[idx_q]);

  // Buffers are deliberately outside reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en && (state_q == IDLE)) begin
      if (wr_sel) mem_b[wr_addr] <= wr_data;
      else        mem_a[wr_addr] <= wr_data;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    expected_d = expected;
    done_d     = done;
    stop_d     = stop;
    err_d      = wr_en && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (go) begin
          if (len_ok) begin
            len_d      = len;
            idx_d      = '0;
            expected_d = '0;
            done_d     = 1'b0;
            stop_d     = 1'b0;
            state_d    = START;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START:  state_d = CLEAR;
      CLEAR:  state_d = SEND_A;
      SEND_A: state_d = SEND_B;
      SEND_B: state_d = ACC;
      ACC: begin
        expected_d = expected + SUM_W'(prod);
        if (last) begin
          stop_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = SEND_A;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    start_d = (state_d == START);
    case (state_d)
      SEND_A:  data_d = mem_a[idx_d];
      SEND_B:  data_d = mem_b[idx_d];
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      data_out <= '0;
      expected <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      start    <= start_d;
      stop     <= stop_d;
      data_out <= data_d;
      expected <= expected_d;
    end
  end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Self-checking bench for dot_product_feeder: table-driven runs, corner-case
// sequences and random runs compared against a cycle-timeline reference model.
module tb_dot_product_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_sel, go;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic [3:0] len;
  logic       busy, done, err, start, stop;
  logic [6:0] data_out;
  logic [10:0] expected;

  int n_cmp  = 0;
  int n_fail = 0;
  int ref_a [8];
  int ref_b [8];
  bit model_done;

  typedef struct {
    int len;
    int a [8];
    int b [8];
    int sum;
  } vec_t;

  vec_t vecs [4];

  dot_product_feeder dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .len(len), .go(go),
    .busy(busy), .done(done), .err(err), .start(start), .stop(stop),
    .data_out(data_out), .expected(expected)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},     32'(busy), 0);
    chk({tag, ".done"},     32'(done), 0);
    chk({tag, ".err"},      32'(err), 0);
    chk({tag, ".start"},    32'(start), 0);
    chk({tag, ".stop"},     32'(stop), 0);
    chk({tag, ".data_out"}, 32'(data_out), 0);
    chk({tag, ".expected"}, 32'(expected), 0);
  endtask

  task automatic load(input bit sel, input int addr, input int val);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = 7'(val);
    tick();
    wr_en = 1'b0;
    if (sel) ref_b[addr] = val; else ref_a[addr] = val;
  endtask

  // Run of n pairs. Cycle c counts from the acceptance edge; the expected
  // outputs for each c follow directly from the documented timeline.
  // inj: cycle to attempt a write+go while busy; rstc: cycle to assert reset;
  // simw: write A[0]=simv in the same cycle as go.
  task automatic run(input int n, input int inj, input int rstc,
                     input bit simw, input int simv);
    int s, k, ph;
    int e_data;
    if (simw) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 7'(simv);
      ref_a[0] = simv;
    end
    go = 1'b1; len = 4'(n);
    tick();
    go = 1'b0; wr_en = 1'b0;
    model_done = 1'b0;
    for (int c = 1; c <= 3 * n + 4; c++) begin
      s = 0;
      for (int j = 0; j < n; j++) if (6 + 3 * j <= c) s += ref_a[j] * ref_b[j];
      e_data = 0;
      if (c >= 3) begin
        k = (c - 3) / 3; ph = (c - 3) % 3;
        if (k < n) e_data = (ph == 0) ? ref_a[k] : (ph == 1) ? ref_b[k] : 0;
      end
      chk($sformatf("busy@c%0d", c),     32'(busy),     32'(c <= 3 * n + 3));
      chk($sformatf("start@c%0d", c),    32'(start),    32'(c == 1));
      chk($sformatf("stop@c%0d", c),     32'(stop),     32'(c >= 3 * n + 3));
      chk($sformatf("done@c%0d", c),     32'(done),     32'(c >= 3 * n + 4));
      chk($sformatf("data_out@c%0d", c), 32'(data_out), 32'(e_data));
      chk($sformatf("expected@c%0d", c), 32'(expected), 32'(s % 2048));
      chk($sformatf("err@c%0d", c),      32'(err),      32'(inj != 0 && c == inj + 1));
      if (c == rstc) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_zero("midrun_rst");
        model_done = 1'b0;
        return;
      end
      if (c == inj) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = 7'd99;
        go = 1'b1; len = 4'd3;
      end
      tick();
      wr_en = 1'b0; go = 1'b0;
    end
    model_done = 1'b1;
  endtask

  task automatic bad_go(input int l);
    go = 1'b1; len = 4'(l);
    tick();
    go = 1'b0;
    chk($sformatf("badlen%0d.err", l),  32'(err),  1);
    chk($sformatf("badlen%0d.busy", l), 32'(busy), 0);
    chk($sformatf("badlen%0d.done", l), 32'(done), 32'(model_done));
    tick();
    chk($sformatf("badlen%0d.err_clr", l), 32'(err),  0);
    chk($sformatf("badlen%0d.idle", l),    32'(busy), 0);
  endtask

  initial begin
    vecs[0].len = 3; vecs[0].sum = 32;
    vecs[0].a = '{1, 2, 3, 0, 0, 0, 0, 0};
    vecs[0].b = '{4, 5, 6, 0, 0, 0, 0, 0};
    vecs[1].len = 8; vecs[1].sum = 8;
    vecs[1].a = '{127, 127, 127, 127, 127, 127, 127, 127};
    vecs[1].b = '{127, 127, 127, 127, 127, 127, 127, 127};
    vecs[2].len = 2; vecs[2].sum = 110;
    vecs[2].a = '{10, 20, 9, 9, 9, 9, 9, 9};
    vecs[2].b = '{3, 4, 9, 9, 9, 9, 9, 9};
    vecs[3].len = 1; vecs[3].sum = 30;
    vecs[3].a = '{5, 1, 1, 1, 1, 1, 1, 1};
    vecs[3].b = '{6, 1, 1, 1, 1, 1, 1, 1};

    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    len = '0; go = 1'b0; model_done = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 2; i++) begin
      wr_en = 1'($urandom); wr_sel = 1'($urandom); wr_addr = 3'($urandom);
      wr_data = 7'($urandom); len = 4'($urandom); go = 1'($urandom);
      tick();
      chk_zero($sformatf("reset%0d", i));
    end
    wr_en = 1'b0; go = 1'b0; len = '0;
    rst_n = 1'b1;
    tick();
    chk("post_reset.busy", 32'(busy), 0);
    chk("post_reset.done", 32'(done), 0);

    // Table-driven runs.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 8; i++) begin
        load(1'b0, i, vecs[v].a[i]);
        load(1'b1, i, vecs[v].b[i]);
      end
      run(vecs[v].len, 0, 0, 1'b0, 0);
      chk($sformatf("vec%0d.final_sum", v), 32'(expected), 32'(vecs[v].sum));
    end

    // Bad lengths after a completed run: done must hold.
    bad_go(0);
    bad_go(9);
    bad_go(15);

    // Busy protection: write A[0]=99 and go mid-run, then re-run.
    load(1'b0, 0, 7); load(1'b1, 0, 2);
    load(1'b0, 1, 3); load(1'b1, 1, 3);
    run(2, 4, 0, 1'b0, 0);
    run(2, 0, 0, 1'b0, 0);
    chk("protect.final_sum", 32'(expected), 23);

    // Reset during SEND_B of pair 1, then a clean len=1 run.
    load(1'b0, 2, 11); load(1'b1, 2, 12);
    run(3, 0, 7, 1'b0, 0);
    chk("after_rst.busy_idle", 32'(busy), 0);
    run(1, 0, 0, 1'b0, 0);
    chk("after_rst.final_sum", 32'(expected), 14);

    // Write coinciding with an accepted go must be seen by the run.
    run(1, 0, 0, 1'b1, 50);
    chk("simw.final_sum", 32'(expected), 100);

    // Random runs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) begin
        load(1'b0, i, int'($urandom_range(0, 127)));
        load(1'b1, i, int'($urandom_range(0, 127)));
      end
      run(int'($urandom_range(1, 8)), (r % 4 == 0) ? 3 : 0, 0, 1'(r % 3 == 1),
          int'($urandom_range(0, 127)));
      if (r % 5 == 0) bad_go((r % 2 == 0) ? 0 : int'($urandom_range(9, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_feeder.md
# dot_product_feeder

Vector source for the dot-product engine. Two small vector buffers, A and B, are loaded through a write port. On `go`, the block drives the engine's `start`, `data_in` and `stop` inputs on the engine's fixed cadence: clear slot, A-load slot, B-load slot, accumulate slot. It also keeps a golden running sum, `expected`, so the engine result can be checked in-system.

## Interface
- `WIDTH`, 7: element width; matches the engine data bus.
- `DEPTH`, 8: maximum vector length (pairs per buffer).
- `ADDR_W`, 3: buffer address width, log2(DEPTH).
- `SUM_W`, 11: width of `expected`; matches the engine accumulator.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  write target: 0 = A, 1 = B.
- `wr_addr`  in  ADDR_W  element index.
- `wr_data`  in  WIDTH  element value.
- `len`  in  ADDR_W+1  pair count, sampled when `go` is accepted.
- `go`  in  1  request a run.
- `busy`  out  1  run in progress.
- `done`  out  1  last run completed; level.
- `err`  out  1  one-cycle pulse for a rejected `go` or write.
- `start`  out  1  to engine `start`.
- `stop`  out  1  to engine `stop`.
- `data_out`  out  WIDTH  to engine `data_in`.
- `expected`  out  SUM_W  golden sum of A[i]*B[i].

## Operation
- Buffers: two DEPTH x WIDTH arrays. They are not cleared by reset.
- Writes:
  - Accepted only while `busy`=0.
  - `wr_en` while `busy`=1 is ignored and pulses `err`.
- States and transitions:
  - IDLE: `busy`=0, `data_out`=0.
    - `go` with 1 <= `len` <= DEPTH: latch `len`, clear index and `expected`, clear `done` and `stop`, go to START.
    - `go` with `len`=0 or `len`>DEPTH: pulse `err`, stay in IDLE, leave `done` unchanged.
  - START: `start`=1 for this cycle only, then CLEAR.
  - CLEAR: one idle slot while the engine clears its accumulator, then SEND_A.
  - SEND_A: `data_out`=A[idx], then SEND_B.
  - SEND_B: `data_out`=B[idx], then ACC.
  - ACC: `data_out`=0; `expected` <= `expected` + A[idx]*B[idx].
    - If idx = len-1: assert `stop`, go to FIN.
    - Otherwise: idx++, go to SEND_A.
  - FIN: set `done`=1, go to IDLE. `stop` and `done` stay high in IDLE until the next accepted `go`.
- Arithmetic:
  - Product is 2*WIDTH bits.
  - Sum is computed modulo 2^SUM_W, i.e. it wraps, identical to the engine's truncation.
- `go` while `busy`=1 is ignored; no `err`.
- Simultaneous `wr_en` and accepted `go` in IDLE: the write commits. The run reads A[0] no earlier than 3 cycles later, so it sees the new value.
- Reset (`rst_n`=0 at an edge), including mid-run:
  - Next cycle: state IDLE, all outputs 0 (`busy`, `done`, `err`, `start`, `stop`, `data_out`, `expected`), idx 0.
  - Buffer contents are retained.

## Timing
- `go` accepted at edge T. Then:
  - `busy`=1 and `start`=1 during cycle T+1.
  - CLEAR during cycle T+2.
- Pair k (0-based):
  - A on `data_out` during cycle T+3+3k.
  - B during cycle T+4+3k.
  - ACC during cycle T+5+3k.
- `stop` rises at the end of the last ACC and is high from cycle T+3+3·len.
- FIN is cycle T+3+3·len. `done` is high and `busy`=0 from cycle T+4+3·len.
- `expected` is final from cycle T+3+3·len.
- Run length: 3·len+3 cycles from acceptance to FIN.
- `err` is registered: high for exactly the one cycle after the offending edge.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs -> every output is 0; release -> IDLE, `busy`=0.
- Basic run: A={1,2,3}, B={4,5,6}, `len`=3, pulse `go` -> `start` pulses once; `data_out` sequence 0,1,4,0,2,5,0,3,6,0; `stop` and `done` as timed; `expected`=32.
- Wrap: all A=B=127, `len`=8 -> `expected`=129032 mod 2048 = 8; FIN at cycle T+27.
- Bad length: `go` with `len`=0, then with `len`=9 -> `err` pulses once each; `busy` stays 0; `done` unchanged.
- Busy protection: during a `len`=2 run, write A[0]=99 and pulse `go` -> write ignored with `err` pulse; `go` ignored; A[0] reads back its old value on the next run.
- Reset mid-run: assert `rst_n`=0 during SEND_B of pair 1 -> next cycle all outputs 0. A following `go` with `len`=1 runs cleanly; `expected`=A[0]*B[0].
